// File: rtl/cmem_port_arbiter.sv
// cmem_port_arbiter
//   Shares the single layer-memory port between NREQ engines (conv write-back,
//   max-pool, flatten). Round-robin arbitration, one access per cycle, with an
//   optional lock so one engine can run an atomic sequence (e.g. the four reads
//   and one write of a 2x2 pool window). Read data is routed back to the
//   requester that issued the read.
//
// Ports
//   clk       rising-edge clock
//   reset     asynchronous, active-low reset
//   req       per-requester access request; command held stable until gnt
//   lock      per-requester: keep ownership after this access
//   we        per-requester: 1 = write, 0 = read
//   sel       per-requester csel,    slice i = [i*SW +: SW]
//   addr      per-requester address, slice i = [i*AW +: AW]
//   wdata     per-requester data,    slice i = [i*DW +: DW]
//   gnt       one-hot grant, combinational in the cycle of the winning req
//   rvalid    one-hot: rdata belongs to requester i this cycle
//   rdata     read data (cdata_rd, forced to 0 when no rvalid)
//   cwr / caddr_wr / cdata_wr    memory write strobe, address, data
//   crd / caddr_rd / cdata_rd    memory read strobe, address, returned data
//   csel      memory select
//   busy      access on the port or a read still in the return pipe
module cmem_port_arbiter #(
    parameter int NREQ   = 3,
    parameter int AW     = 12,
    parameter int DW     = 20,
    parameter int SW     = 3,
    parameter int RD_LAT = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      lock,
    input  logic [NREQ-1:0]      we,
    input  logic [NREQ*SW-1:0]   sel,
    input  logic [NREQ*AW-1:0]   addr,
    input  logic [NREQ*DW-1:0]   wdata,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      rvalid,
    output logic [DW-1:0]        rdata,
    output logic                 cwr,
    output logic [AW-1:0]        caddr_wr,
    output logic [DW-1:0]        cdata_wr,
    output logic                 crd,
    output logic [AW-1:0]        caddr_rd,
    input  logic [DW-1:0]        cdata_rd,
    output logic [SW-1:0]        csel,
    output logic                 busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {ST_ARB, ST_LOCK} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   owner_q, owner_d;

    logic            cwr_q, cwr_d;
    logic            crd_q, crd_d;
    logic [AW-1:0]   caddr_wr_q, caddr_wr_d;
    logic [AW-1:0]   caddr_rd_q, caddr_rd_d;
    logic [DW-1:0]   cdata_wr_q, cdata_wr_d;
    logic [SW-1:0]   csel_q, csel_d;

    // Entry 0 lines up with crd; entry RD_LAT lines up with the returned data.
    logic [RD_LAT:0][NREQ-1:0] rd_pipe_q, rd_pipe_d;

    logic            rr_found;
    logic [PW-1:0]   rr_idx;
    logic            win_vld;
    logic [PW-1:0]   win_idx;
    logic [NREQ-1:0] gnt_raw;
    logic [NREQ-1:0] rd_issue;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] i);
        return (i == PW'(NREQ - 1)) ? '0 : i + 1'b1;
    endfunction

    // Round-robin search: first requester at or after ptr, wrapping.
    always_comb begin
        int            cand;
        logic [PW-1:0] cidx;
        rr_found = 1'b0;
        rr_idx   = '0;
        cand     = 0;
        cidx     = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= NREQ) cand = cand - NREQ;
            cidx = PW'(cand);
            if (!rr_found && req[cidx]) begin
                rr_found = 1'b1;
                rr_idx   = cidx;
            end
        end
    end

    // Ownership FSM and winner selection.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        win_vld = 1'b0;
        win_idx = rr_idx;
        case (state_q)
            ST_ARB: begin
                if (rr_found) begin
                    win_vld = 1'b1;
                    ptr_d   = wrap_inc(rr_idx);
                    if (lock[rr_idx]) begin
                        state_d = ST_LOCK;
                        owner_d = rr_idx;
                    end
                end
            end
            ST_LOCK: begin
                // ptr already points past the owner since the locking grant.
                win_idx = owner_q;
                if (req[owner_q]) begin
                    win_vld = 1'b1;
                    if (!lock[owner_q]) begin
                        state_d = ST_ARB;
                        ptr_d   = wrap_inc(owner_q);
                    end
                end else begin
                    state_d = ST_ARB;
                    ptr_d   = wrap_inc(owner_q);
                end
            end
            default: state_d = ST_ARB;
        endcase
    end

    assign gnt_raw = win_vld ? (NREQ'(1) << win_idx) : '0;

    // Command issue: captured at the edge closing the grant cycle.
    always_comb begin
        cwr_d      = win_vld & we[win_idx];
        crd_d      = win_vld & ~we[win_idx];
        caddr_wr_d = caddr_wr_q;
        caddr_rd_d = caddr_rd_q;
        cdata_wr_d = cdata_wr_q;
        csel_d     = csel_q;
        if (cwr_d) begin
            caddr_wr_d = addr[win_idx*AW +: AW];
            cdata_wr_d = wdata[win_idx*DW +: DW];
        end
        if (crd_d) caddr_rd_d = addr[win_idx*AW +: AW];
        if (win_vld) csel_d = sel[win_idx*SW +: SW];
        rd_issue  = crd_d ? gnt_raw : '0;
        rd_pipe_d = {rd_pipe_q[RD_LAT-1:0], rd_issue};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_ARB;
            ptr_q      <= '0;
            owner_q    <= '0;
            cwr_q      <= 1'b0;
            crd_q      <= 1'b0;
            caddr_wr_q <= '0;
            caddr_rd_q <= '0;
            cdata_wr_q <= '0;
            csel_q     <= '0;
            rd_pipe_q  <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            cwr_q      <= cwr_d;
            crd_q      <= crd_d;
            caddr_wr_q <= caddr_wr_d;
            caddr_rd_q <= caddr_rd_d;
            cdata_wr_q <= cdata_wr_d;
            csel_q     <= csel_d;
            rd_pipe_q  <= rd_pipe_d;
        end
    end

    // gnt is combinational from req, so it is masked while reset is held.
    assign gnt      = reset ? gnt_raw : '0;
    assign rvalid   = rd_pipe_q[RD_LAT];
    assign rdata    = (|rvalid) ? cdata_rd : '0;
    assign cwr      = cwr_q;
    assign crd      = crd_q;
    assign caddr_wr = caddr_wr_q;
    assign caddr_rd = caddr_rd_q;
    assign cdata_wr = cdata_wr_q;
    assign csel     = csel_q;
    assign busy     = cwr_q | crd_q | (|rd_pipe_q[RD_LAT:1]);

endmodule

// File: tb/tb_cmem_port_arbiter.sv
module tb_cmem_port_arbiter;
    localparam int NREQ = 3;
    localparam int AW   = 12;
    localparam int DW   = 20;
    localparam int SW   = 3;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [NREQ-1:0]     req, lock, we;
    logic [NREQ*SW-1:0]  sel;
    logic [NREQ*AW-1:0]  addr;
    logic [NREQ*DW-1:0]  wdata;
    logic [NREQ-1:0]     gnt, rvalid;
    logic [DW-1:0]       rdata;
    logic                cwr, crd, busy;
    logic [AW-1:0]       caddr_wr, caddr_rd;
    logic [DW-1:0]       cdata_wr, cdata_rd;
    logic [SW-1:0]       csel;

    cmem_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .SW(SW), .RD_LAT(1)) dut (
        .clk(clk), .reset(reset), .req(req), .lock(lock), .we(we), .sel(sel),
        .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr), .crd(crd),
        .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .csel(csel), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory contents seen by reads.
    function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
        return (a == 12'h020) ? 20'h12345 : ({a[7:0], a} ^ 20'h5A5A5);
    endfunction

    // Reference model: round-robin pointer plus optional locked owner.
    int m_ptr   = 0;
    int m_owner = -1;
    int last_g  = -1;

    function automatic int model_grant();
        int g = -1;
        int i;
        if (m_owner >= 0) begin
            if (req[m_owner]) begin
                g = m_owner;
                if (!lock[m_owner]) begin
                    m_ptr   = (m_owner + 1) % NREQ;
                    m_owner = -1;
                end
            end else begin
                m_ptr   = (m_owner + 1) % NREQ;
                m_owner = -1;
            end
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                i = (m_ptr + k) % NREQ;
                if (g < 0 && req[i]) g = i;
            end
            if (g >= 0) begin
                m_ptr = (g + 1) % NREQ;
                if (lock[g]) m_owner = g;
            end
        end
        return g;
    endfunction

    typedef struct {
        int             due;
        logic           w;
        logic [AW-1:0]  a;
        logic [DW-1:0]  d;
        logic [SW-1:0]  s;
    } cmd_t;

    typedef struct {
        int             due;
        int             id;
        logic [DW-1:0]  d;
    } rd_t;

    cmd_t cmd_q[$];
    rd_t  rd_q[$];

    task automatic set_cmd(input int i, input logic r, input logic l, input logic w,
                           input logic [SW-1:0] s, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        req[i]              = r;
        lock[i]             = l;
        we[i]               = w;
        sel[i*SW +: SW]     = s;
        addr[i*AW +: AW]    = a;
        wdata[i*DW +: DW]   = d;
    endtask

    // One clock cycle: check the grant, push expected responses, advance.
    task automatic step(output logic [NREQ-1:0] gs);
        int   g;
        cmd_t c;
        rd_t  r;
        @(negedge clk);
        gs = gnt;
        g  = model_grant();
        chk("gnt", gnt, (g >= 0) ? (1 << g) : 0);
        if (g >= 0) begin
            c.due = cyc + 1;
            c.w   = we[g];
            c.a   = addr[g*AW +: AW];
            c.d   = wdata[g*DW +: DW];
            c.s   = sel[g*SW +: SW];
            cmd_q.push_back(c);
            if (!we[g]) begin
                r.due = cyc + 2;
                r.id  = g;
                r.d   = mem_fn(c.a);
                rd_q.push_back(r);
            end
        end
        last_g = g;
        @(posedge clk);
        #1;
    endtask

    // Memory responder: data for a crd cycle appears in the following cycle.
    initial begin
        logic          rq;
        logic [AW-1:0] ra;
        cdata_rd = '0;
        forever begin
            @(negedge clk);
            rq = crd;
            ra = caddr_rd;
            @(posedge clk);
            #2;
            cdata_rd = rq ? mem_fn(ra) : DW'($urandom);
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a command or rvalid.
    always @(negedge clk) begin
        if (reset) begin
            logic eb;
            cmd_t c;
            rd_t  r;
            chk("cwr_crd_excl", {31'd0, cwr & crd}, 0);
            eb = (cmd_q.size() > 0 && cmd_q[0].due == cyc) ||
                 (rd_q.size() > 0 && rd_q[0].due <= cyc + 1);
            chk("busy", {31'd0, busy}, {31'd0, eb});
            if (cwr || crd) begin
                if (cmd_q.size() == 0) begin
                    chk("unexpected_cmd", {30'd0, cwr, crd}, 0);
                end else begin
                    c = cmd_q.pop_front();
                    chk("cmd_cycle", cyc, c.due);
                    chk("cmd_kind", {31'd0, cwr}, {31'd0, c.w});
                    if (c.w) begin
                        chk("caddr_wr", {20'd0, caddr_wr}, {20'd0, c.a});
                        chk("cdata_wr", {12'd0, cdata_wr}, {12'd0, c.d});
                    end else begin
                        chk("caddr_rd", {20'd0, caddr_rd}, {20'd0, c.a});
                    end
                    chk("csel", {29'd0, csel}, {29'd0, c.s});
                end
            end else if (cmd_q.size() > 0 && cmd_q[0].due <= cyc) begin
                c = cmd_q.pop_front();
                chk("missing_cmd", {30'd0, cwr, crd}, c.w ? 2 : 1);
            end
            if (rvalid != '0) begin
                if (rd_q.size() == 0) begin
                    chk("unexpected_rvalid", {29'd0, rvalid}, 0);
                end else begin
                    r = rd_q.pop_front();
                    chk("rvalid_cycle", cyc, r.due);
                    chk("rvalid", {29'd0, rvalid}, 1 << r.id);
                    chk("rdata", {12'd0, rdata}, {12'd0, r.d});
                end
            end else if (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
                r = rd_q.pop_front();
                chk("missing_rvalid", {29'd0, rvalid}, 1 << r.id);
            end
        end
    end

    task automatic clear_all();
        for (int i = 0; i < NREQ; i++) set_cmd(i, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    initial begin
        logic [NREQ-1:0] gs;
        req = '0; lock = '0; we = '0; sel = '0; addr = '0; wdata = '0;
        #1 reset = 1'b0;
        req = '1;
        #3;
        chk("rst_gnt", {29'd0, gnt}, 0);
        chk("rst_cwr_crd", {30'd0, cwr, crd}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_rvalid", {29'd0, rvalid}, 0);
        chk("rst_caddr_wr", {20'd0, caddr_wr}, 0);
        chk("rst_csel", {29'd0, csel}, 0);
        req = '0;
        @(posedge clk); #1;
        reset = 1'b1;
        m_ptr = 0; m_owner = -1;

        // Three writers, no lock: strict rotation.
        for (int i = 0; i < NREQ; i++)
            set_cmd(i, 1'b1, 1'b0, 1'b1, SW'(i + 1), AW'(12'h100 + i), DW'(20'hA0000 + i));
        for (int k = 0; k < 6; k++) begin
            step(gs);
            chk("t2_gnt", {29'd0, gs}, {29'd0, 3'b001 << (k % 3)});
        end
        clear_all();

        // Single write from requester 0.
        set_cmd(0, 1'b1, 1'b0, 1'b1, 3'b001, 12'h041, 20'h00ABC);
        step(gs);
        chk("t1_gnt", {29'd0, gs}, 3'b001);
        clear_all();
        chk("t1_cwr", {31'd0, cwr}, 1);
        chk("t1_crd", {31'd0, crd}, 0);
        chk("t1_caddr_wr", {20'd0, caddr_wr}, 32'h041);
        chk("t1_cdata_wr", {12'd0, cdata_wr}, 32'h00ABC);
        chk("t1_csel", {29'd0, csel}, 3'b001);

        // Single read from requester 1.
        set_cmd(1, 1'b1, 1'b0, 1'b0, 3'b010, 12'h020, 20'h0);
        step(gs);
        chk("t3_gnt", {29'd0, gs}, 3'b010);
        clear_all();
        chk("t3_crd", {31'd0, crd}, 1);
        chk("t3_caddr_rd", {20'd0, caddr_rd}, 32'h020);
        chk("t3_rvalid_early", {29'd0, rvalid}, 0);
        step(gs);
        #2;
        chk("t3_rvalid", {29'd0, rvalid}, 3'b010);
        chk("t3_rdata", {12'd0, rdata}, 32'h12345);
        step(gs);
        chk("t3_rvalid_once", {29'd0, rvalid}, 0);

        // Locked sequence from requester 2 with others contending.
        set_cmd(0, 1'b1, 1'b0, 1'b1, 3'b001, 12'h300, 20'h11111);
        set_cmd(1, 1'b1, 1'b0, 1'b1, 3'b010, 12'h301, 20'h22222);
        for (int k = 0; k < 4; k++) begin
            set_cmd(2, 1'b1, k < 3, k == 3, 3'b100, AW'(12'h200 + k), DW'(20'hC0000 + k));
            step(gs);
            chk("t4_lock_gnt", {29'd0, gs}, 3'b100);
        end
        req[2] = 1'b0;
        step(gs);
        chk("t4_after_gnt", {29'd0, gs}, 3'b001);
        clear_all();
        for (int k = 0; k < 4; k++) step(gs);

        // Write to 7FF then go idle.
        set_cmd(0, 1'b1, 1'b0, 1'b1, 3'b011, 12'h7FF, 20'h55555);
        step(gs);
        clear_all();
        step(gs);
        chk("t6_cwr", {31'd0, cwr}, 0);
        chk("t6_crd", {31'd0, crd}, 0);
        chk("t6_caddr_wr", {20'd0, caddr_wr}, 32'h7FF);
        chk("t6_busy", {31'd0, busy}, 0);
        step(gs);
        chk("t6_caddr_hold", {20'd0, caddr_wr}, 32'h7FF);

        // Reset while a read is on the port.
        set_cmd(1, 1'b1, 1'b0, 1'b0, 3'b010, 12'h0F0, 20'h0);
        step(gs);
        for (int i = 0; i < NREQ; i++)
            set_cmd(i, 1'b1, 1'b0, 1'b1, SW'(i), AW'(12'h400 + i), DW'(20'h0F000 + i));
        #2;
        chk("t5_crd_before", {31'd0, crd}, 1);
        reset = 1'b0;
        cmd_q.delete();
        rd_q.delete();
        m_ptr = 0; m_owner = -1;
        #1;
        chk("t5_gnt", {29'd0, gnt}, 0);
        chk("t5_cwr_crd", {30'd0, cwr, crd}, 0);
        chk("t5_caddr_rd", {20'd0, caddr_rd}, 0);
        chk("t5_csel", {29'd0, csel}, 0);
        chk("t5_busy", {31'd0, busy}, 0);
        chk("t5_rvalid", {29'd0, rvalid}, 0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        chk("t5_rvalid_after", {29'd0, rvalid}, 0);
        step(gs);
        chk("t5_first_gnt", {29'd0, gs}, 3'b001);
        clear_all();
        for (int k = 0; k < 3; k++) step(gs);

        // Randomized traffic: commands held until granted, random lock runs.
        last_g = -1;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (last_g == i || !req[i]) begin
                    if ($urandom_range(0, 1) == 1)
                        set_cmd(i, 1'b1, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
                                SW'($urandom), AW'($urandom), DW'($urandom));
                    else
                        req[i] = 1'b0;
                end
            end
            step(gs);
        end
        clear_all();
        for (int k = 0; k < 6; k++) step(gs);
        chk("drain_cmd", cmd_q.size(), 0);
        chk("drain_rd", rd_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
